// File: rtl/switch_reader.sv
// Memory-mapped DIP switch / push button input port: synchronise, debounce, latch
// button presses as sticky flags, and return switch state or flags on a chip-selected read.
module switch_reader #(
    parameter int unsigned SW_W            = 16,
    parameter int unsigned BTN_W           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic             switch_clk,
    input  logic             switchrst,
    input  logic             switchcs,
    input  logic             switchread,
    input  logic [1:0]       switchaddr,
    input  logic [SW_W-1:0]  sw_raw,
    input  logic [BTN_W-1:0] btn_raw,
    output logic [15:0]      switchrdata,
    output logic             btn_pending
);

    localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_W-1:0]  sw_meta, sw_sync, sw_cand, sw_deb;
    logic [CW-1:0]    sw_cnt;
    logic [BTN_W-1:0] btn_meta, btn_sync, btn_cand, btn_deb, btn_deb_q;
    logic [CW-1:0]    btn_cnt [BTN_W];
    logic [BTN_W-1:0] flags, flags_next, rise, clr;
    logic             rd_en;
    logic [15:0]      sw_ext, flags_ext;

    // Two-stage synchronisers for the asynchronous pins.
    always_ff @(posedge switch_clk or negedge switchrst) begin
        if (!switchrst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw_raw;
            sw_sync  <= sw_meta;
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // The switch vector debounces as one unit: any bit changing restarts the count.
    always_ff @(posedge switch_clk or negedge switchrst) begin
        if (!switchrst) begin
            sw_cand <= '0;
            sw_cnt  <= '0;
            sw_deb  <= '0;
        end else if (sw_sync != sw_cand) begin
            sw_cand <= sw_sync;
            sw_cnt  <= '0;
        end else if (sw_cnt == CNT_MAX) begin
            sw_deb  <= sw_cand;
        end else begin
            sw_cnt  <= sw_cnt + 1'b1;
        end
    end

    always_ff @(posedge switch_clk or negedge switchrst) begin
        if (!switchrst) begin
            btn_cand <= '0;
            btn_cnt  <= '{default: '0};
            btn_deb  <= '0;
        end else begin
            for (int i = 0; i < BTN_W; i++) begin
                if (btn_sync[i] != btn_cand[i]) begin
                    btn_cand[i] <= btn_sync[i];
                    btn_cnt[i]  <= '0;
                end else if (btn_cnt[i] == CNT_MAX) begin
                    btn_deb[i]  <= btn_cand[i];
                end else begin
                    btn_cnt[i]  <= btn_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_en      = switchcs & switchread;
        rise       = btn_deb & ~btn_deb_q;
        clr        = (rd_en && switchaddr == 2'b10) ? flags : '0;
        // A rise coinciding with a clearing read survives and is left for the next read.
        flags_next = (flags & ~clr) | rise;
        sw_ext     = '0;
        sw_ext[SW_W-1:0]   = sw_deb;
        flags_ext  = '0;
        flags_ext[BTN_W-1:0] = flags;
    end

    always_ff @(posedge switch_clk or negedge switchrst) begin
        if (!switchrst) begin
            btn_deb_q   <= '0;
            flags       <= '0;
            switchrdata <= '0;
        end else begin
            btn_deb_q <= btn_deb;
            flags     <= flags_next;
            if (rd_en) begin
                unique case (switchaddr)
                    2'b00:   switchrdata <= sw_ext;
                    2'b10:   switchrdata <= flags_ext;
                    default: switchrdata <= '0;
                endcase
            end
        end
    end

    assign btn_pending = |flags;

endmodule

// File: doc/switch_reader.md
Name: switch_reader

Overview:
- Memory-mapped input peripheral for the board's DIP switches and push buttons. It is the read-side counterpart of the LED output port.
- Synchronises and debounces raw switch and button pins, and latches button presses as sticky flags.
- Returns switch state or press flags to the CPU through MemOrIO on a chip-selected read. Reading the flags clears the flags that were returned.
- Sits beside the LED block on cpu_clk.

Parameters:
- SW_W, 16, number of switch inputs (max 16).
- BTN_W, 5, number of button inputs (max 16).
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles required before an input is accepted (≥2). Benches use 4.

Ports:
- switch_clk  in  1  clock (cpu_clk).
- switchrst  in  1  reset, asynchronous, active-low.
- switchcs  in  1  chip select from MemOrIO; 1 = switch block addressed.
- switchread  in  1  read strobe; a read occurs when switchcs & switchread at a rising edge.
- switchaddr  in  2  2'b00 = switch vector, 2'b10 = button press flags, others = zero.
- sw_raw  in  SW_W  raw switch pins (asynchronous).
- btn_raw  in  BTN_W  raw button pins, active-high (asynchronous).
- switchrdata  out  16  registered read data.
- btn_pending  out  1  OR of all press flags (polling/interrupt hint).

Behaviour:
- Reset (switchrst==0, async):
  - All synchroniser, candidate, counter, debounced and flag registers go to 0.
  - switchrdata = 16'h0000, btn_pending = 0.
  - Asserting reset mid-debounce or mid-read discards all state. There is no partial read.
- Synchroniser: 2-FF chain per input bit. Stage-2 output is called sync.
- Debounce, one instance for the whole switch vector and one per button bit. Each instance has a candidate register cand and a counter cnt of width $clog2(DEBOUNCE_CYCLES).
  - If sync != cand: cand <= sync, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= cand, cnt holds (saturates).
  - Else: cnt <= cnt+1.
  - Latency: a raw change held stable reaches deb at rising edge DEBOUNCE_CYCLES+3 after it is first sampled. With D=4 this is edge 7.
  - A glitch shorter than DEBOUNCE_CYCLES stable cycles never reaches deb.
  - Any change during counting restarts the count.
- Press flags, BTN_W bits:
  - rise = deb_btn & ~deb_btn_q, where deb_btn_q is deb_btn delayed one cycle. rise is a single-cycle pulse.
  - Update: flags <= (flags & ~clr) | rise.
  - clr = flags when a read of addr 2'b10 occurs this edge, else 0.
  - A new rise on the same edge as a clearing read stays set. It is not lost, and it is not returned by that read.
  - Button releases do not change flags.
  - A second press before the read collapses into the same flag.
- Read path: at the rising edge where switchcs & switchread:
  - addr 00: switchrdata <= zero-extended deb_sw.
  - addr 10: switchrdata <= zero-extended flags (the pre-clear value).
  - addr 01/11: switchrdata <= 16'h0000, and the flags are not cleared.
  - Latency is one cycle: data is valid the cycle after the strobe and holds until the next read or reset.
  - Without a read, switchrdata holds its last value.
- A read with switchread=1 and switchcs=0 has no effect.
- Back-to-back reads on consecutive cycles are legal. Each read is handled independently.
- btn_pending = |flags (registered-flag derived, no extra latency).

Test Plan (DEBOUNCE_CYCLES=4, SW_W=16, BTN_W=5):
1. Reset, then hold sw_raw=16'hA5C3 for 10 cycles, then read addr 00 → switchrdata=16'hA5C3 the cycle after the read. A read at edge 5 after the change still returns 16'h0000.
2. Toggle sw_raw bit0 high for 2 cycles then low, then read addr 00 → bit0 reads 0 (glitch rejected).
3. Press btn_raw[2] for 8 cycles, release → btn_pending=1. Read addr 10 → 16'h0004, and btn_pending=0 the next cycle. A second read of addr 10 → 16'h0000.
4. Align a new btn_raw[0] debounced rise with a read of addr 10 while flag2 is set → read returns 16'h0004, then flags=5'b00001 and btn_pending stays 1.
5. Set flag1, then read addr 01 and addr 11 → switchrdata=16'h0000 and flag1 is still set. Read with switchcs=0 → switchrdata unchanged.
6. Set flags and switches, then assert switchrst low asynchronously mid-debounce → switchrdata=0, btn_pending=0 immediately. After release, state rebuilds only after full debounce.
